commit_ctrl: RTL and testbench
==============================

// Module: commit_ctrl
// PURPOSE
//  In-order retirement sequencer between the scoreboard head and the commit datapath.
//  Retires at most one instruction per cycle and drives the GPR write port.
//  Serialises CSR instructions through a req/gnt handshake with the CSR file.
//  Raises a multi-cycle pipeline flush after exceptions, CSR ops and fences.
// PARAMETERS
//  FLUSH_CYCLES  2    cycles flush_o is held after a serialising retire (>=1)
//  CSR_TIMEOUT   64   cycles in CSR_WAIT without csr_gnt_i before abort (>=1)
// PORTS
//  clk_i           in   1   clock; all state updates on rising edge
//  rst_ni          in   1   reset, synchronous, active-low
//  head_valid_i    in   1   scoreboard head entry is finished and ready to retire
//  head_is_csr_i   in   1   head is a CSR instruction
//  head_is_fence_i in   1   head is FENCE/FENCE.I
//  head_ex_i       in   1   head carries an exception
//  head_op_i       in   8   fu_op of head, passed to CSR file
//  head_rd_i       in   5   destination register
//  head_result_i   in   32  ALU result / CSR write operand
//  head_pc_i       in   32  PC of head
//  halt_i          in   1   debug halt: start no new retirement
//  commit_ack_o    out  1   head consumed this cycle (scoreboard pops)
//  gpr_we_o        out  1   GPR write enable
//  gpr_waddr_o     out  5   GPR write address
//  gpr_wdata_o     out  32  GPR write data
//  csr_req_o       out  1   CSR access request
//  csr_op_o        out  8   CSR operation (registered copy of head_op_i)
//  csr_wdata_o     out  32  CSR write operand (registered copy of head_result_i)
//  csr_gnt_i       in   1   CSR access done; csr_rdata_i valid this cycle
//  csr_rdata_i     in   32  old CSR value
//  ex_valid_o      out  1   one-cycle exception pulse
//  ex_pc_o         out  32  PC of excepting/aborted instruction
//  csr_timeout_o   out  1   one-cycle pulse: CSR access aborted
//  flush_o         out  1   flush front-end/issue
//  retire_cnt_o    out  64  retired-instruction count
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): state=RUN, flush/timeout counters=0, retire_cnt_o=0,
//   captured CSR regs=0; all 1-bit outputs 0, buses 0 while idle. Reset mid-CSR or
//   mid-flush drops csr_req_o/flush_o after that edge.
//  Outputs are combinational from state + inputs; retirement is 0-cycle latency in RUN.
//  RUN, head_valid_i=1, halt_i=0, priority top-down:
//   head_ex_i: ack=1, ex_valid_o=1, ex_pc_o=head_pc_i, no GPR write, no count -> FLUSH
//   head_is_csr_i: no ack; capture op/result/rd/pc -> CSR_WAIT
//   head_is_fence_i: ack=1, retire_cnt+1 -> FLUSH
//   else: ack=1, gpr_we_o=(rd!=0), waddr=rd, wdata=result, retire_cnt+1; stay RUN
//  RUN with halt_i=1 or head_valid_i=0: no ack, no write.
//  CSR_WAIT: csr_req_o=1, op/wdata from captured regs, stable until gnt; head_* ignored.
//   csr_gnt_i=1: ack=1, gpr_we_o=(rd!=0), wdata=csr_rdata_i, retire_cnt+1 -> FLUSH
//   no gnt: wait counter+1; at counter==CSR_TIMEOUT-1 without gnt: ack=1,
//    csr_timeout_o=1, ex_valid_o=1, ex_pc_o=captured pc, no write, no count -> FLUSH
//   gnt and timeout same cycle: gnt wins. halt_i ignored in CSR_WAIT.
//  FLUSH: flush_o=1 exactly FLUSH_CYCLES cycles, no ack, head_* ignored -> RUN.
//  retire_cnt_o: 64-bit, wraps 2^64-1 -> 0. Wait counter cleared on entering CSR_WAIT.
// TESTING
//  3 back-to-back ALU heads rd=1,2,0 -> ack 3 cycles, we=1,1,0, retire_cnt=3, no flush
//  CSR head, gnt 3 cycles later rdata=0xDEAD_BEEF rd=5 -> req held 3 cyc, x5<=DEADBEEF,
//   then flush_o=1 for 2 cycles, retire_cnt+1
//  head_ex_i, pc=0x8000_0010 -> ex_valid_o pulse, ex_pc_o=0x80000010, no we, cnt unchanged
//  CSR head, gnt never (TIMEOUT=64) -> timeout+ex pulse 64th CSR_WAIT cycle, ack, flush
//  halt_i=1 with head_valid -> no ack; halt during CSR_WAIT -> CSR still completes
//  rst_ni=0 mid-CSR_WAIT -> next cycle csr_req_o=0, retire_cnt_o=0, state RUN

Source files
------------

// File: rtl/commit_ctrl.sv
// In-order retirement sequencer: one instruction per cycle, CSR
// serialisation through req/gnt, and a timed flush after serialising retires.
module commit_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CSR_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        head_valid_i,
    input  logic        head_is_csr_i,
    input  logic        head_is_fence_i,
    input  logic        head_ex_i,
    input  logic [7:0]  head_op_i,
    input  logic [4:0]  head_rd_i,
    input  logic [31:0] head_result_i,
    input  logic [31:0] head_pc_i,
    input  logic        halt_i,
    output logic        commit_ack_o,
    output logic        gpr_we_o,
    output logic [4:0]  gpr_waddr_o,
    output logic [31:0] gpr_wdata_o,
    output logic        csr_req_o,
    output logic [7:0]  csr_op_o,
    output logic [31:0] csr_wdata_o,
    input  logic        csr_gnt_i,
    input  logic [31:0] csr_rdata_i,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic        csr_timeout_o,
    output logic        flush_o,
    output logic [63:0] retire_cnt_o
);

    typedef enum logic [1:0] {RUN, CSR_WAIT, FLUSH} state_t;

    localparam int TW = (CSR_TIMEOUT > 1) ? $clog2(CSR_TIMEOUT) : 1;
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CSR_TIMEOUT - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FLUSH_CYCLES - 1);

    state_t        state, state_d;
    logic [TW-1:0] wait_cnt;
    logic [FW-1:0] flush_cnt;
    logic [7:0]    cap_op;
    logic [31:0]   cap_wdata;
    logic [4:0]    cap_rd;
    logic [31:0]   cap_pc;
    logic          cap_en;
    logic          cnt_inc;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= RUN;
            wait_cnt     <= '0;
            flush_cnt    <= '0;
            retire_cnt_o <= '0;
            cap_op       <= '0;
            cap_wdata    <= '0;
            cap_rd       <= '0;
            cap_pc       <= '0;
        end else begin
            state <= state_d;
            // Counters only run while in their state, so entry always starts at 0
            wait_cnt  <= (state == CSR_WAIT) ? wait_cnt + TW'(1) : '0;
            flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
            if (cnt_inc) retire_cnt_o <= retire_cnt_o + 64'd1;
            if (cap_en) begin
                cap_op    <= head_op_i;
                cap_wdata <= head_result_i;
                cap_rd    <= head_rd_i;
                cap_pc    <= head_pc_i;
            end
        end
    end

    always_comb begin
        state_d       = state;
        cap_en        = 1'b0;
        cnt_inc       = 1'b0;
        commit_ack_o  = 1'b0;
        gpr_we_o      = 1'b0;
        gpr_waddr_o   = '0;
        gpr_wdata_o   = '0;
        csr_req_o     = 1'b0;
        csr_op_o      = '0;
        csr_wdata_o   = '0;
        ex_valid_o    = 1'b0;
        ex_pc_o       = '0;
        csr_timeout_o = 1'b0;
        flush_o       = 1'b0;
        unique case (state)
            RUN: begin
                if (head_valid_i && !halt_i) begin
                    if (head_ex_i) begin
                        commit_ack_o = 1'b1;
                        ex_valid_o   = 1'b1;
                        ex_pc_o      = head_pc_i;
                        state_d      = FLUSH;
                    end else if (head_is_csr_i) begin
                        cap_en  = 1'b1;
                        state_d = CSR_WAIT;
                    end else if (head_is_fence_i) begin
                        commit_ack_o = 1'b1;
                        cnt_inc      = 1'b1;
                        state_d      = FLUSH;
                    end else begin
                        commit_ack_o = 1'b1;
                        gpr_we_o     = (head_rd_i != 5'd0);
                        gpr_waddr_o  = head_rd_i;
                        gpr_wdata_o  = head_result_i;
                        cnt_inc      = 1'b1;
                    end
                end
            end
            CSR_WAIT: begin
                csr_req_o   = 1'b1;
                csr_op_o    = cap_op;
                csr_wdata_o = cap_wdata;
                if (csr_gnt_i) begin
                    commit_ack_o = 1'b1;
                    gpr_we_o     = (cap_rd != 5'd0);
                    gpr_waddr_o  = cap_rd;
                    gpr_wdata_o  = csr_rdata_i;
                    cnt_inc      = 1'b1;
                    state_d      = FLUSH;
                end else if (wait_cnt == T_LAST) begin
                    commit_ack_o  = 1'b1;
                    csr_timeout_o = 1'b1;
                    ex_valid_o    = 1'b1;
                    ex_pc_o       = cap_pc;
                    state_d       = FLUSH;
                end
            end
            FLUSH: begin
                flush_o = 1'b1;
                if (flush_cnt == F_LAST) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: driver pushes expected retirements,
// a negedge monitor pops and compares on every commit_ack_o.
module tb_commit_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        head_valid_i, head_is_csr_i, head_is_fence_i, head_ex_i;
    logic [7:0]  head_op_i;
    logic [4:0]  head_rd_i;
    logic [31:0] head_result_i, head_pc_i;
    logic        halt_i;
    logic        commit_ack_o, gpr_we_o;
    logic [4:0]  gpr_waddr_o;
    logic [31:0] gpr_wdata_o;
    logic        csr_req_o;
    logic [7:0]  csr_op_o;
    logic [31:0] csr_wdata_o;
    logic        csr_gnt_i;
    logic [31:0] csr_rdata_i;
    logic        ex_valid_o;
    logic [31:0] ex_pc_o;
    logic        csr_timeout_o, flush_o;
    logic [63:0] retire_cnt_o;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex;
        logic [31:0] ex_pc;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    commit_ctrl #(.FLUSH_CYCLES(2), .CSR_TIMEOUT(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .head_valid_i(head_valid_i), .head_is_csr_i(head_is_csr_i),
        .head_is_fence_i(head_is_fence_i), .head_ex_i(head_ex_i),
        .head_op_i(head_op_i), .head_rd_i(head_rd_i),
        .head_result_i(head_result_i), .head_pc_i(head_pc_i),
        .halt_i(halt_i), .commit_ack_o(commit_ack_o),
        .gpr_we_o(gpr_we_o), .gpr_waddr_o(gpr_waddr_o),
        .gpr_wdata_o(gpr_wdata_o), .csr_req_o(csr_req_o),
        .csr_op_o(csr_op_o), .csr_wdata_o(csr_wdata_o),
        .csr_gnt_i(csr_gnt_i), .csr_rdata_i(csr_rdata_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .csr_timeout_o(csr_timeout_o), .flush_o(flush_o),
        .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_head();
        head_valid_i    = 1'b0;
        head_is_csr_i   = 1'b0;
        head_is_fence_i = 1'b0;
        head_ex_i       = 1'b0;
        head_op_i       = '0;
        head_rd_i       = '0;
        head_result_i   = '0;
        head_pc_i       = '0;
    endtask

    task automatic push(input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic ex,
                        input logic [31:0] pc, input logic tmo);
        exp_t e;
        e.we = we; e.waddr = wa; e.wdata = wd;
        e.ex = ex; e.ex_pc = pc; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic csr_head(input logic [7:0] op, input logic [4:0] rd,
                            input logic [31:0] wd, input logic [31:0] pc);
        idle_head();
        head_valid_i  = 1'b1;
        head_is_csr_i = 1'b1;
        head_op_i     = op;
        head_rd_i     = rd;
        head_result_i = wd;
        head_pc_i     = pc;
    endtask

    task automatic expect_flush(input string tag);
        chk({tag, "_flush1"}, 64'(flush_o), 64'd1);
        tick();
        chk({tag, "_flush2"}, 64'(flush_o), 64'd1);
        tick();
        chk({tag, "_flush_end"}, 64'(flush_o), 64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && commit_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 64'(commit_ack_o), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_we", 64'(gpr_we_o), 64'(e.we));
                chk("mon_waddr", 64'(gpr_waddr_o), 64'(e.waddr));
                chk("mon_wdata", 64'(gpr_wdata_o), 64'(e.wdata));
                chk("mon_ex", 64'(ex_valid_o), 64'(e.ex));
                chk("mon_ex_pc", 64'(ex_pc_o), 64'(e.ex_pc));
                chk("mon_timeout", 64'(csr_timeout_o), 64'(e.tmo));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        halt_i      = 1'b0;
        csr_gnt_i   = 1'b0;
        csr_rdata_i = '0;
        idle_head();
        tick();
        tick();
        chk("rst_cnt", retire_cnt_o, 64'd0);
        chk("rst_flush", 64'(flush_o), 64'd0);
        chk("rst_req", 64'(csr_req_o), 64'd0);
        chk("rst_ack", 64'(commit_ack_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Three back-to-back ALU retirements
        for (int i = 0; i < 3; i++) begin
            logic [4:0]  rd;
            logic [31:0] res;
            rd  = (i == 2) ? 5'd0 : 5'(i + 1);
            res = 32'h1000 + 32'(i);
            idle_head();
            head_valid_i  = 1'b1;
            head_rd_i     = rd;
            head_result_i = res;
            push(rd != 0, rd, res, 1'b0, 32'h0, 1'b0);
            tick();
        end
        idle_head();
        chk("alu_cnt", retire_cnt_o, 64'd3);
        chk("alu_noflush", 64'(flush_o), 64'd0);

        // CSR granted on the third request cycle
        csr_head(8'h5A, 5'd5, 32'h1234, 32'h100);
        tick();
        idle_head();
        for (int i = 0; i < 2; i++) begin
            chk("csr_req", 64'(csr_req_o), 64'd1);
            chk("csr_op", 64'(csr_op_o), 64'h5A);
            chk("csr_wdata", 64'(csr_wdata_o), 64'h1234);
            chk("csr_noack", 64'(commit_ack_o), 64'd0);
            tick();
        end
        chk("csr_req3", 64'(csr_req_o), 64'd1);
        csr_gnt_i   = 1'b1;
        csr_rdata_i = 32'hDEAD_BEEF;
        push(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        tick();
        csr_gnt_i   = 1'b0;
        csr_rdata_i = '0;
        expect_flush("csr");
        chk("csr_cnt", retire_cnt_o, 64'd4);

        // Exception retire
        idle_head();
        head_valid_i  = 1'b1;
        head_ex_i     = 1'b1;
        head_rd_i     = 5'd7;
        head_result_i = 32'h7777;
        head_pc_i     = 32'h8000_0010;
        push(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0010, 1'b0);
        tick();
        idle_head();
        expect_flush("ex");
        chk("ex_cnt", retire_cnt_o, 64'd4);

        // Halt blocks retirement
        head_valid_i  = 1'b1;
        head_rd_i     = 5'd3;
        head_result_i = 32'h3333;
        halt_i        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("halt_noack", 64'(commit_ack_o), 64'd0);
            tick();
        end
        chk("halt_cnt", retire_cnt_o, 64'd4);
        halt_i = 1'b0;

        // Halt raised during CSR_WAIT does not stop completion
        csr_head(8'h11, 5'd6, 32'h55, 32'h200);
        tick();
        idle_head();
        halt_i = 1'b1;
        tick();
        csr_gnt_i   = 1'b1;
        csr_rdata_i = 32'hCAFE_0001;
        push(1'b1, 5'd6, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0);
        tick();
        csr_gnt_i = 1'b0;
        halt_i    = 1'b0;
        expect_flush("hcsr");
        chk("hcsr_cnt", retire_cnt_o, 64'd5);

        // CSR never granted: abort on the 64th wait cycle
        csr_head(8'h22, 5'd9, 32'h99, 32'h300);
        tick();
        idle_head();
        for (int i = 0; i < 63; i++) begin
            if (i == 0 || i == 62) begin
                chk("tmo_req", 64'(csr_req_o), 64'd1);
                chk("tmo_early", 64'(csr_timeout_o), 64'd0);
            end
            tick();
        end
        push(1'b0, 5'd0, 32'h0, 1'b1, 32'h300, 1'b1);
        chk("tmo_pulse", 64'(csr_timeout_o), 64'd1);
        tick();
        chk("tmo_once", 64'(csr_timeout_o), 64'd0);
        expect_flush("tmo");
        chk("tmo_cnt", retire_cnt_o, 64'd5);

        // Reset in the middle of CSR_WAIT
        csr_head(8'h33, 5'd4, 32'h44, 32'h400);
        tick();
        idle_head();
        tick();
        chk("mid_req", 64'(csr_req_o), 64'd1);
        rst_ni = 1'b0;
        tick();
        chk("mid_rst_req", 64'(csr_req_o), 64'd0);
        chk("mid_rst_cnt", retire_cnt_o, 64'd0);
        chk("mid_rst_flush", 64'(flush_o), 64'd0);
        rst_ni = 1'b1;
        head_valid_i  = 1'b1;
        head_rd_i     = 5'd8;
        head_result_i = 32'hABCD;
        push(1'b1, 5'd8, 32'hABCD, 1'b0, 32'h0, 1'b0);
        tick();
        idle_head();
        chk("post_rst_cnt", retire_cnt_o, 64'd1);

        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
